// File: rtl/ctrl_decode_pipe_if.sv
// rtl/ctrl_decode_pipe_if.sv - D-stage inputs and E-stage control outputs of the decode/issue stage
interface ctrl_decode_pipe_if;
    logic [31:0] instr_d;
    logic        valid_d;
    logic        flush_e;
    logic [2:0]  imm_src_d;
    logic        stall_d;
    logic        valid_e;
    logic        reg_write_e;
    logic        alu_src_e;
    logic        mem_write_e;
    logic        jump_e;
    logic        branch_e;
    logic        jal_src_e;
    logic        u_src_e;
    logic        uo_control_e;
    logic        muldiv_e;
    logic        illegal_e;
    logic [1:0]  result_src_e;
    logic [1:0]  alu_op_e;
    logic [4:0]  rd_e;
    logic        div_busy;

    modport master (
        output instr_d, valid_d, flush_e,
        input  imm_src_d, stall_d, valid_e, reg_write_e, alu_src_e, mem_write_e,
               jump_e, branch_e, jal_src_e, u_src_e, uo_control_e, muldiv_e,
               illegal_e, result_src_e, alu_op_e, rd_e, div_busy
    );

    modport slave (
        input  instr_d, valid_d, flush_e,
        output imm_src_d, stall_d, valid_e, reg_write_e, alu_src_e, mem_write_e,
               jump_e, branch_e, jal_src_e, u_src_e, uo_control_e, muldiv_e,
               illegal_e, result_src_e, alu_op_e, rd_e, div_busy
    );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// rtl/ctrl_decode_pipe.sv - RV32I decode, D/E control register, load-use and divide-hold stall
module ctrl_decode_pipe #(
    parameter bit          ENABLE_M   = 1'b0,
    parameter int unsigned DIV_CYCLES = 8,
    parameter bit          RD0_GATE   = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    ctrl_decode_pipe_if.slave  bus
);
    localparam int CW = $clog2(DIV_CYCLES + 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    typedef struct packed {
        logic       regWrite;
        logic       aluSrc;
        logic       memWrite;
        logic       jump;
        logic       branch;
        logic       jalSrc;
        logic       uSrc;
        logic       uoControl;
        logic       muldiv;
        logic       illegal;
        logic [1:0] resultSrc;
        logic [1:0] aluOp;
        logic [4:0] rd;
    } ctl_t;

    logic [6:0] opcode;
    logic [4:0] rdField, rs1, rs2;
    logic [6:0] funct7;
    ctl_t       dec, eCtl;
    logic [2:0] immSrc;
    logic       usesRs1, usesRs2;
    logic       eValid;
    logic [CW-1:0] divCnt;
    logic       divBusy, loadUse, isDiv;

    assign opcode  = bus.instr_d[6:0];
    assign rdField = bus.instr_d[11:7];
    assign rs1     = bus.instr_d[19:15];
    assign rs2     = bus.instr_d[24:20];
    assign funct7  = bus.instr_d[31:25];

    always_comb begin
        dec     = '0;
        immSrc  = 3'b000;
        usesRs1 = 1'b0;
        usesRs2 = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec.regWrite = 1'b1; dec.aluOp = 2'b10; usesRs1 = 1'b1; usesRs2 = 1'b1;
                if (ENABLE_M && funct7 == 7'b0000001) begin
                    dec.aluOp = 2'b11; dec.muldiv = 1'b1;
                end
            end
            7'b0010011: begin
                dec.regWrite = 1'b1; dec.aluSrc = 1'b1; dec.aluOp = 2'b10; usesRs1 = 1'b1;
            end
            7'b0000011: begin
                dec.regWrite = 1'b1; dec.aluSrc = 1'b1; dec.resultSrc = 2'b01; usesRs1 = 1'b1;
            end
            7'b0100011: begin
                dec.aluSrc = 1'b1; dec.memWrite = 1'b1; immSrc = 3'b001;
                usesRs1 = 1'b1; usesRs2 = 1'b1;
            end
            7'b1100011: begin
                dec.branch = 1'b1; dec.aluOp = 2'b01; immSrc = 3'b010;
                usesRs1 = 1'b1; usesRs2 = 1'b1;
            end
            7'b1101111: begin
                dec.regWrite = 1'b1; dec.jump = 1'b1; dec.resultSrc = 2'b10; immSrc = 3'b011;
            end
            7'b1100111: begin
                dec.regWrite = 1'b1; dec.jump = 1'b1; dec.jalSrc = 1'b1;
                dec.resultSrc = 2'b10; usesRs1 = 1'b1;
            end
            7'b0110111: begin
                dec.regWrite = 1'b1; dec.resultSrc = 2'b11; immSrc = 3'b100; dec.uoControl = 1'b1;
            end
            7'b0010111: begin
                dec.regWrite = 1'b1; dec.resultSrc = 2'b11; immSrc = 3'b100; dec.uSrc = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        // Illegal encodings carry no destination so they can never trigger a hazard.
        dec.rd = dec.illegal ? 5'd0 : rdField;
        if (rdField == 5'd0 && (RD0_GATE || opcode == 7'b0010011))
            dec.regWrite = 1'b0;
    end

    assign isDiv   = dec.muldiv & bus.instr_d[14];
    assign divBusy = (divCnt != '0);
    assign loadUse = bus.valid_d & eValid & (eCtl.resultSrc == 2'b01) & (eCtl.rd != 5'd0) &
                     ((usesRs1 & (rs1 == eCtl.rd)) | (usesRs2 & (rs2 == eCtl.rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eValid <= 1'b0;
            eCtl   <= '0;
            divCnt <= '0;
        end else if (bus.flush_e) begin
            eValid <= 1'b0;
            eCtl   <= '0;
            divCnt <= '0;
        end else if (divBusy) begin
            divCnt <= divCnt - CW'(1);
        end else if (loadUse) begin
            eValid <= 1'b0;
            eCtl   <= '0;
        end else begin
            eValid <= bus.valid_d;
            eCtl   <= bus.valid_d ? dec : '0;
            if (bus.valid_d && isDiv)
                divCnt <= DIV_LOAD;
        end
    end

    assign bus.imm_src_d    = immSrc;
    assign bus.stall_d      = loadUse | divBusy;
    assign bus.valid_e      = eValid;
    assign bus.reg_write_e  = eCtl.regWrite;
    assign bus.alu_src_e    = eCtl.aluSrc;
    assign bus.mem_write_e  = eCtl.memWrite;
    assign bus.jump_e       = eCtl.jump;
    assign bus.branch_e     = eCtl.branch;
    assign bus.jal_src_e    = eCtl.jalSrc;
    assign bus.u_src_e      = eCtl.uSrc;
    assign bus.uo_control_e = eCtl.uoControl;
    assign bus.muldiv_e     = eCtl.muldiv;
    assign bus.illegal_e    = eCtl.illegal;
    assign bus.result_src_e = eCtl.resultSrc;
    assign bus.alu_op_e     = eCtl.aluOp;
    assign bus.rd_e         = eCtl.rd;
    assign bus.div_busy     = divBusy;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb/tb_ctrl_decode_pipe.sv - scoreboard bench for ctrl_decode_pipe against a behavioural pipeline model
module tb_ctrl_decode_pipe;
    typedef struct packed {
        logic       valid, regWrite, aluSrc, memWrite, jump, branch, jalSrc, uSrc, uoControl, muldiv, illegal;
        logic [1:0] resultSrc, aluOp;
        logic [4:0] rd;
    } ectl_t;

    typedef struct packed {
        ectl_t      e;
        logic       divBusy;
        logic       stall;
        logic [2:0] imm;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        valid = 1'b0;
    logic        flush = 1'b0;

    ctrl_decode_pipe_if ifA();
    ctrl_decode_pipe_if ifB();

    assign ifA.instr_d = instr;
    assign ifA.valid_d = valid;
    assign ifA.flush_e = flush;
    assign ifB.instr_d = instr;
    assign ifB.valid_d = valid;
    assign ifB.flush_e = flush;

    ctrl_decode_pipe #(.ENABLE_M(1'b1), .DIV_CYCLES(4), .RD0_GATE(1'b1)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
    ctrl_decode_pipe #(.ENABLE_M(1'b0), .DIV_CYCLES(1), .RD0_GATE(1'b0)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));

    always #5 clk = ~clk;

    obs_t actA, actB;
    assign actA = {ifA.valid_e, ifA.reg_write_e, ifA.alu_src_e, ifA.mem_write_e, ifA.jump_e, ifA.branch_e,
                   ifA.jal_src_e, ifA.u_src_e, ifA.uo_control_e, ifA.muldiv_e, ifA.illegal_e,
                   ifA.result_src_e, ifA.alu_op_e, ifA.rd_e, ifA.div_busy, ifA.stall_d, ifA.imm_src_d};
    assign actB = {ifB.valid_e, ifB.reg_write_e, ifB.alu_src_e, ifB.mem_write_e, ifB.jump_e, ifB.branch_e,
                   ifB.jal_src_e, ifB.u_src_e, ifB.uo_control_e, ifB.muldiv_e, ifB.illegal_e,
                   ifB.result_src_e, ifB.alu_op_e, ifB.rd_e, ifB.div_busy, ifB.stall_d, ifB.imm_src_d};

    obs_t  qA[$], qB[$];
    ectl_t eA = '0, eB = '0;
    int    leftA = 0, leftB = 0;
    int    total = 0, bad = 0, cyc = 0;

    // Decoded controls straight from the opcode table; u1/u2 say whether rs1/rs2 are read.
    task automatic refDecode(input logic [31:0] ins, input bit enM, input bit rd0g,
                             output ectl_t d, output logic [2:0] imm, output bit u1, output bit u2);
        bit w;
        d = '0; imm = 3'b000; u1 = 0; u2 = 0; w = 0;
        d.valid = 1'b1;
        case (ins[6:0])
            7'h33: begin w = 1; d.aluOp = 2; u1 = 1; u2 = 1;
                         if (enM && ins[31:25] == 7'h01) begin d.aluOp = 3; d.muldiv = 1; end end
            7'h13: begin w = 1; d.aluSrc = 1; d.aluOp = 2; u1 = 1; end
            7'h03: begin w = 1; d.aluSrc = 1; d.resultSrc = 1; u1 = 1; end
            7'h23: begin d.aluSrc = 1; d.memWrite = 1; imm = 1; u1 = 1; u2 = 1; end
            7'h63: begin d.branch = 1; d.aluOp = 1; imm = 2; u1 = 1; u2 = 1; end
            7'h6F: begin w = 1; d.jump = 1; d.resultSrc = 2; imm = 3; end
            7'h67: begin w = 1; d.jump = 1; d.jalSrc = 1; d.resultSrc = 2; u1 = 1; end
            7'h37: begin w = 1; d.resultSrc = 3; imm = 4; d.uoControl = 1; end
            7'h17: begin w = 1; d.resultSrc = 3; imm = 4; d.uSrc = 1; end
            default: d.illegal = 1;
        endcase
        d.rd = d.illegal ? 5'd0 : ins[11:7];
        d.regWrite = w && !(ins[11:7] == 5'd0 && (rd0g || ins[6:0] == 7'h13));
    endtask

    // Observation for the current cycle, then the E contents after the coming edge.
    task automatic modelStep(input int dc, input bit enM, input bit rd0g, input logic [31:0] ins,
                             input logic v, input logic f, input logic r,
                             inout ectl_t e, inout int left, output obs_t o);
        ectl_t d; logic [2:0] imm; bit u1, u2, lu, busy;
        refDecode(ins, enM, rd0g, d, imm, u1, u2);
        o = '0;
        o.imm = imm;
        if (r) begin e = '0; left = 0; return; end
        busy = left > 0;
        lu = v && e.valid && e.resultSrc == 2'b01 && e.rd != 5'd0 &&
             ((u1 && ins[19:15] == e.rd) || (u2 && ins[24:20] == e.rd));
        o.e = e; o.divBusy = busy; o.stall = lu || busy;
        if (f) begin e = '0; left = 0; end
        else if (busy) left = left - 1;
        else if (lu) e = '0;
        else begin
            e = v ? d : '0;
            left = (v && d.muldiv && ins[14]) ? dc - 1 : 0;
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic f, input logic r, output logic stA);
        obs_t oa, ob;
        @(posedge clk); #1;
        instr = ins; valid = v; flush = f; rst_n = !r;
        modelStep(4, 1, 1, ins, v, f, r, eA, leftA, oa);
        modelStep(1, 0, 0, ins, v, f, r, eB, leftB, ob);
        qA.push_back(oa);
        qB.push_back(ob);
        stA = oa.stall;
    endtask

    task automatic issue(input logic [31:0] ins);
        logic st; int n;
        n = 0;
        do begin drive(ins, 1'b1, 1'b0, 1'b0, st); n++; end while (st && n < 20);
    endtask

    logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F, 7'h0F};
    logic [6:0] f7s [3]  = '{7'h00, 7'h20, 7'h01};

    function automatic logic [31:0] randInstr();
        logic [31:0] x;
        x = $urandom;
        x[6:0]   = ops[$urandom_range(0, 10)];
        x[11:7]  = 5'($urandom_range(0, 3));
        x[19:15] = 5'($urandom_range(0, 3));
        x[24:20] = 5'($urandom_range(0, 3));
        if (x[6:0] == 7'h33) x[31:25] = f7s[$urandom_range(0, 2)];
        return x;
    endfunction

    always @(negedge clk) begin
        obs_t ex;
        cyc++;
        if (qA.size() > 0) begin
            ex = qA.pop_front();
            total++;
            if (actA !== ex) begin
                bad++;
                $display("FAIL dutA_cycle%0d actual=%h required=%h", cyc, actA, ex);
            end
        end
        if (qB.size() > 0) begin
            ex = qB.pop_front();
            total++;
            if (actB !== ex) begin
                bad++;
                $display("FAIL dutB_cycle%0d actual=%h required=%h", cyc, actB, ex);
            end
        end
    end

    initial begin
        logic st;
        logic [31:0] cur;
        logic v, f, r;
        drive(32'h0, 1'b0, 1'b0, 1'b1, st);
        drive(32'h0, 1'b0, 1'b0, 1'b1, st);
        issue(32'h0000A103);
        issue(32'h001101B3);
        issue(32'h00000013);
        issue(32'h027342B3);
        issue(32'h00208033);
        issue(32'h0000007F);
        issue(32'h027342B3);
        issue(32'h027342B3);
        issue(32'h00000013);
        issue(32'h027342B3);
        drive(32'h00000013, 1'b1, 1'b0, 1'b0, st);
        drive(32'h00000013, 1'b1, 1'b1, 1'b0, st);
        issue(32'h00000013);
        issue(32'h0000A103);
        drive(32'h001101B3, 1'b1, 1'b0, 1'b1, st);
        issue(32'h001101B3);
        issue(32'h027342B3);
        drive(32'h00000013, 1'b1, 1'b0, 1'b1, st);
        issue(32'h00000013);
        st = 1'b0;
        cur = 32'h0;
        for (int i = 0; i < 600; i++) begin
            if (!st) cur = randInstr();
            v = ($urandom_range(0, 7) != 0);
            f = ($urandom_range(0, 24) == 0);
            r = ($urandom_range(0, 99) == 0);
            drive(cur, v, f, r, st);
        end
        @(negedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ctrl_decode_pipe.md
# ctrl_decode_pipe

Parametrised decode-and-issue control stage for the pipelined RV32I core. Decodes the D-stage instruction into the core's control signals, with optional M-extension decode and rd=x0 write gating for all writing opcodes, plus illegal-opcode flagging. Registers the controls into the D/E pipeline boundary with valid tracking. Owns load-use hazard detection and a multi-cycle divide hold, and drives the F/D stall.

## Interface
- ENABLE_M, 0: 1 decodes R-type funct7=0000001 as mul/div.
- DIV_CYCLES, 8: cycles a divide occupies E (≥1); mul is single-cycle.
- RD0_GATE, 1: 1 suppresses RegWrite for rd=x0 on every opcode; 0 gates I-type only.
- clk  in  1  core clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- instr_d  in  32  D-stage instruction (opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25]).
- valid_d  in  1  instr_d holds a real instruction.
- flush_e  in  1  taken branch/jump; kill E contents.
- imm_src_d  out  3  combinational immediate select for the D-stage immediate generator.
- stall_d  out  1  combinational; hold the F and D registers.
- valid_e, reg_write_e, alu_src_e, mem_write_e, jump_e, branch_e, jal_src_e, u_src_e, uo_control_e, muldiv_e, illegal_e  out  1 each  registered E-stage controls.
- result_src_e  out  2  registered; alu_op_e  out  2  registered; rd_e  out  5  registered.
- div_busy  out  1  registered divide still occupying E.

## Operation
- Defaults are all zero. Per opcode, the non-zero fields are:
  - 0110011 R: RegWrite, ALUOp=10. With ENABLE_M and funct7=0000001: ALUOp=11, muldiv=1.
  - 0010011 I: RegWrite, ALUSrc, ALUOp=10, Imm=000.
  - 0000011 load: RegWrite, ALUSrc, ResultSrc=01, Imm=000.
  - 0100011 store: ALUSrc, MemWrite, Imm=001.
  - 1100011 branch: Branch, ALUOp=01, Imm=010.
  - 1101111 jal: RegWrite, Jump, ResultSrc=10, Imm=011.
  - 1100111 jalr: RegWrite, Jump, JalSrc, ResultSrc=10, Imm=000.
  - 0110111 lui: RegWrite, ResultSrc=11, Imm=100, UOControl.
  - 0010111 auipc: RegWrite, ResultSrc=11, Imm=100, USrc.
  - Any other opcode: all zero, illegal=1.
- RegWrite is cleared when rd=0, subject to RD0_GATE.
- A divide is muldiv=1 with funct3[2]=1.
- Register-use rules:
  - uses_rs1: R, I, load, store, branch, jalr.
  - uses_rs2: R, store, branch.
- Load-use hazard (lu) = valid_d & valid_e & result_src_e==01 & rd_e!=0 & ((uses_rs1 & rs1_d==rd_e) | (uses_rs2 & rs2_d==rd_e)).
- stall_d = lu | div_busy.
- E-register next state, in priority order:
  1. flush_e: bubble (all E outputs 0); divide counter cleared.
  2. div_busy: hold all E outputs.
  3. lu: bubble.
  4. Otherwise capture the decode. valid_e=valid_d; with valid_d=0 all controls are 0 (illegal_e only when valid_d=1).
- Divide counter:
  - Width $clog2(DIV_CYCLES+1).
  - Loads DIV_CYCLES-1 when a divide is captured; decrements while non-zero.
  - div_busy = counter!=0.

## Timing
- Reset: every registered output and the counter go to 0 immediately on rst_n low. stall_d evaluates to 0.
- Decode-to-E latency is 1 cycle. imm_src_d and stall_d are same-cycle combinational.
- A load-use hazard inserts exactly one bubble; the dependent instruction reaches E on the following cycle.
- A divide is in E for DIV_CYCLES cycles with stall_d high for DIV_CYCLES-1 cycles. DIV_CYCLES=1 never stalls.
- Simultaneous events:
  - flush_e with lu or div_busy: flush wins and stall_d drops the next cycle.
  - Back-to-back divides: the second is captured on the cycle div_busy falls, and the counter reloads.
- Reset mid-divide aborts the divide; no residual stall after release.

## Test plan
- Assert rst_n low mid-stream with E populated → all E outputs, div_busy and stall_d read 0 before the next clk edge.
- lw x2,0(x1) (0x0000A103), valid_d=1 → next cycle valid_e=1, reg_write_e=1, alu_src_e=1, result_src_e=01, rd_e=2; imm_src_d=000 same cycle.
- lw x2 followed by add x3,x2,x1 (0x001101B3) → stall_d=1 for one cycle, E bubble (valid_e=0), then add in E with alu_op_e=10, rd_e=3.
- ENABLE_M=1, DIV_CYCLES=4, div x5,x6,x7 (0x027342B3) → muldiv_e=1, alu_op_e=11; div_busy/stall_d high 3 cycles; E held throughout; next instruction enters on cycle 5.
- Same divide with flush_e pulsed on its 2nd E cycle → next cycle valid_e=0, div_busy=0, stall_d=0.
- add x0,x1,x2 (0x00208033): RD0_GATE=1 → reg_write_e=0; RD0_GATE=0 → reg_write_e=1. Opcode 0x0000007F → illegal_e=1, all other controls 0.
